// File: rtl/b_ev_randombit_loader_pkg.sv
// Shared ER parameters for the EV random bit loader: word widths, default depth and FSM encoding.
package b_ev_randombit_loader_pkg;

    localparam int unsigned EV_W          = 64;
    localparam int unsigned EV_IN_W       = 32;
    localparam int unsigned EV_DEPTH_DEF  = 16384;
    localparam int unsigned EV_ADDR_W_DEF = 14;
    localparam int unsigned EV_WEA_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_FULL    = 2'd3
    } ev_state_e;

endpackage

// File: rtl/b_ev_randombit_loader_word_packer.sv
// ev_word_packer: pairs two 32-bit words into one 64-bit BRAM write and registers
// the port-A strobe, address and data so they are valid for exactly one cycle.
module ev_word_packer
    import b_ev_randombit_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = EV_ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                hi_load,
    input  logic                lo_write,
    input  logic [EV_IN_W-1:0]  in_data,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic [EV_WEA_W-1:0] wea,
    output logic [ADDR_W-1:0]   addra,
    output logic [EV_W-1:0]     dina
);

    logic [EV_IN_W-1:0]  hi_q, hi_d;
    logic [EV_WEA_W-1:0] wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [EV_W-1:0]     dina_q, dina_d;

    // First word of a pair lands in the upper half of the BRAM word.
    always_comb begin
        hi_d    = hi_q;
        wea_d   = '0;
        addra_d = addra_q;
        dina_d  = dina_q;
        if (flush) begin
            hi_d = '0;
        end else if (hi_load) begin
            hi_d = in_data;
        end else if (lo_write) begin
            wea_d   = '1;
            addra_d = wr_addr;
            dina_d  = {hi_q, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            wea_q   <= '0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            hi_q    <= hi_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    assign wea   = wea_q;
    assign addra = addra_q;
    assign dina  = dina_q;

endmodule

// File: rtl/b_ev_randombit_loader.sv
// Loads Bob's EV random bit BRAM (port A) from a 32-bit valid/ready stream and flags full.
// Optional running XOR checksum output when EV_LOADER_CHECKSUM_EN is defined.
module b_ev_randombit_loader
    import b_ev_randombit_loader_pkg::*;
#(
    parameter int unsigned EV_DEPTH  = EV_DEPTH_DEF,
    parameter int unsigned EV_ADDR_W = EV_ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_ev_load,
    input  logic                 reset_er_parameter,
    input  logic [EV_IN_W-1:0]   ev_in_data,
    input  logic                 ev_in_valid,
    output logic                 ev_in_ready,
    output logic                 EVrandombit_clka,
    output logic                 EVrandombit_ena,
    output logic                 EVrandombit_rsta,
    output logic [EV_WEA_W-1:0]  EVrandombit_wea,
    output logic [EV_ADDR_W-1:0] EVrandombit_addra,
    output logic [EV_W-1:0]      EVrandombit_dina,
    output logic                 EVrandombit_full,
    output logic                 ev_load_busy,
    output logic [EV_ADDR_W:0]   ev_word_count
`ifdef EV_LOADER_CHECKSUM_EN
    ,
    output logic [EV_IN_W-1:0]   ev_checksum
`endif
);

    localparam int unsigned CNT_W = EV_ADDR_W + 1;

    ev_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             hi_acc;
    logic             lo_acc;
    logic             last_pair;

    // Reset pulse suppresses any capture or new strobe in its own cycle.
    assign accept    = ev_in_valid && ready_q;
    assign hi_acc    = accept && (state_q == ST_WAIT_HI) && !reset_er_parameter;
    assign lo_acc    = accept && (state_q == ST_WAIT_LO) && !reset_er_parameter;
    assign last_pair = (count_q + CNT_W'(1)) == CNT_W'(EV_DEPTH);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        full_d  = full_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ev_load) begin
                    state_d = ST_WAIT_HI;
                    count_d = '0;
                end
            end
            ST_WAIT_HI: begin
                if (hi_acc) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (lo_acc) begin
                    count_d = count_q + CNT_W'(1);
                    if (last_pair) begin
                        state_d = ST_FULL;
                        full_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_HI;
                    end
                end
            end
            ST_FULL: begin
                full_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (reset_er_parameter) begin
            state_d = ST_IDLE;
            count_d = '0;
            full_d  = 1'b0;
        end
        ready_d = (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);
        busy_d  = ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    ev_word_packer #(
        .ADDR_W (EV_ADDR_W)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (reset_er_parameter),
        .hi_load  (hi_acc),
        .lo_write (lo_acc),
        .in_data  (ev_in_data),
        .wr_addr  (count_q[EV_ADDR_W-1:0]),
        .wea      (EVrandombit_wea),
        .addra    (EVrandombit_addra),
        .dina     (EVrandombit_dina)
    );

`ifdef EV_LOADER_CHECKSUM_EN
    logic [EV_IN_W-1:0] cks_q, cks_d;

    // Accepts only happen in the wait states, so the value freezes once FULL is reached.
    always_comb begin
        cks_d = cks_q;
        if (reset_er_parameter || ((state_q == ST_IDLE) && start_ev_load)) begin
            cks_d = '0;
        end else if (accept) begin
            cks_d = cks_q ^ ev_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign ev_checksum = cks_q;
`endif

    assign EVrandombit_clka = clk;
    assign EVrandombit_ena  = 1'b1;
    assign EVrandombit_rsta = 1'b0;
    assign EVrandombit_full = full_q;
    assign ev_in_ready      = ready_q;
    assign ev_load_busy     = busy_q;
    assign ev_word_count    = count_q;

endmodule

// File: tb/tb_b_ev_randombit_loader.sv
// Randomized bench for b_ev_randombit_loader against a word-list reference model (EV_DEPTH=4).
module tb_b_ev_randombit_loader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_ev_load = 1'b0;
    logic          reset_er_parameter = 1'b0;
    logic [31:0]   ev_in_data = '0;
    logic          ev_in_valid = 1'b0;
    logic          ev_in_ready;
    logic          EVrandombit_clka;
    logic          EVrandombit_ena;
    logic          EVrandombit_rsta;
    logic [7:0]    EVrandombit_wea;
    logic [AW-1:0] EVrandombit_addra;
    logic [63:0]   EVrandombit_dina;
    logic          EVrandombit_full;
    logic          ev_load_busy;
    logic [AW:0]   ev_word_count;
`ifdef EV_LOADER_CHECKSUM_EN
    logic [31:0]   ev_checksum;
`endif

    b_ev_randombit_loader #(.EV_DEPTH(DEPTH), .EV_ADDR_W(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_ev_load      (start_ev_load),
        .reset_er_parameter (reset_er_parameter),
        .ev_in_data         (ev_in_data),
        .ev_in_valid        (ev_in_valid),
        .ev_in_ready        (ev_in_ready),
        .EVrandombit_clka   (EVrandombit_clka),
        .EVrandombit_ena    (EVrandombit_ena),
        .EVrandombit_rsta   (EVrandombit_rsta),
        .EVrandombit_wea    (EVrandombit_wea),
        .EVrandombit_addra  (EVrandombit_addra),
        .EVrandombit_dina   (EVrandombit_dina),
        .EVrandombit_full   (EVrandombit_full),
        .ev_load_busy       (ev_load_busy),
        .ev_word_count      (ev_word_count)
`ifdef EV_LOADER_CHECKSUM_EN
        ,
        .ev_checksum        (ev_checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  wea;
        int          addr;
        logic [63:0] data;
        int          cnt;
        logic        full;
    } ob_t;

    wr_t exp_q[$];
    ob_t obs_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a load is a list of accepted words; pair i is written at address i.
    bit          m_active = 0;
    bit          m_full   = 0;
    int          m_nw     = 0;
    int          m_count  = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_ck     = '0;

    // Observation log of every BRAM strobe seen by the bench.
    always @(negedge clk) begin
        if (EVrandombit_wea !== 8'h00) begin
            ob_t o;
            o.wea  = EVrandombit_wea;
            o.addr = int'(EVrandombit_addra);
            o.data = EVrandombit_dina;
            o.cnt  = int'(ev_word_count);
            o.full = EVrandombit_full;
            obs_q.push_back(o);
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic st, input logic rer);
        wr_t w;
        ev_in_valid        = v;
        ev_in_data         = d;
        start_ev_load      = st;
        reset_er_parameter = rer;
        if (rer) begin
            m_active = 0; m_full = 0; m_nw = 0; m_count = 0; m_ck = '0;
        end else if (v && m_active) begin
            m_ck = m_ck ^ d;
            if (m_nw % 2 == 0) begin
                m_hi = d;
            end else begin
                w.addr = m_nw / 2;
                w.data = {m_hi, d};
                exp_q.push_back(w);
            end
            m_nw++;
            m_count = m_nw / 2;
            if (m_nw == 2 * int'(DEPTH)) begin
                m_active = 0;
                m_full   = 1;
            end
        end else if (st && !m_active && !m_full) begin
            m_active = 1; m_nw = 0; m_count = 0; m_ck = '0;
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        n_cmp += 7;
        if (ev_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", ev_in_ready); end
        if (EVrandombit_wea !== 8'h00) begin n_fail++; $display("FAIL rst_wea got %h want 00", EVrandombit_wea); end
        if (EVrandombit_addra !== '0) begin n_fail++; $display("FAIL rst_addra got %h want 0", EVrandombit_addra); end
        if (EVrandombit_dina !== 64'h0) begin n_fail++; $display("FAIL rst_dina got %h want 0", EVrandombit_dina); end
        if (EVrandombit_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b want 0", EVrandombit_full); end
        if (ev_load_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", ev_load_busy); end
        if (ev_word_count !== '0) begin n_fail++; $display("FAIL rst_count got %0d want 0", ev_word_count); end
        n_cmp += 2;
        if (EVrandombit_ena !== 1'b1 || EVrandombit_rsta !== 1'b0) begin
            n_fail++; $display("FAIL rst_const got ena=%b rsta=%b want 1/0", EVrandombit_ena, EVrandombit_rsta);
        end
        if (EVrandombit_clka !== clk) begin n_fail++; $display("FAIL clka got %b want %b", EVrandombit_clka, clk); end
    endtask

    task automatic test_basic_fill();
        clear_logs();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (ev_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_on got %b want 1", ev_in_ready); end
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        n_cmp += 3;
        if (EVrandombit_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", EVrandombit_full); end
        if (ev_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_off got %b want 0", ev_in_ready); end
        if (ev_word_count !== 3'(m_count)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", ev_word_count, m_count); end
        step(1'b1, 32'hDEAD0000, 1'b1, 1'b0);
        step(1'b1, 32'hDEAD0001, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp += 3;
        if (EVrandombit_full !== 1'b1 || ev_in_ready !== 1'b0 || ev_load_busy !== 1'b0) begin
            n_fail++; $display("FAIL fill_hold got full=%b ready=%b busy=%b want 1/0/0", EVrandombit_full, ev_in_ready, ev_load_busy);
        end
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL fill_nwr got %0d want %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() > 0 && obs_q[0].data !== 64'h0000000100000002) begin
            n_fail++; $display("FAIL fill_first got %h want 0000000100000002", obs_q[0].data);
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                n_cmp++;
                if (obs_q[i].wea !== 8'hFF || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
                    obs_q[i].cnt !== exp_q[i].addr + 1 || obs_q[i].full !== (exp_q[i].addr == int'(DEPTH) - 1)) begin
                    n_fail++;
                    $display("FAIL fill_wr%0d got wea=%h a=%0d d=%h cnt=%0d full=%b want a=%0d d=%h", i, obs_q[i].wea,
                             obs_q[i].addr, obs_q[i].data, obs_q[i].cnt, obs_q[i].full, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_cmp++;
        if (EVrandombit_full !== 1'b0 || ev_word_count !== '0) begin
            n_fail++; $display("FAIL fill_rearm got full=%b count=%0d want 0/0", EVrandombit_full, ev_word_count);
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        clear_logs();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        while (!m_full && guard < 300) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0);
            n_cmp++;
            if (ev_in_ready !== 1'(m_active) || ev_word_count !== 3'(m_count)) begin
                n_fail++; $display("FAIL bp_cycle got ready=%b count=%0d want %b/%0d", ev_in_ready, ev_word_count, m_active, m_count);
            end
            guard++;
        end
        n_cmp++;
        if (!m_full) begin n_fail++; $display("FAIL bp_timeout got words=%0d want %0d", m_nw, 2 * DEPTH); end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp += 2;
        if (ev_word_count !== 3'(DEPTH)) begin n_fail++; $display("FAIL bp_count got %0d want %0d", ev_word_count, DEPTH); end
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_nwr got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                n_cmp++;
                if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                    n_fail++; $display("FAIL bp_wr%0d got a=%0d d=%h want a=%0d d=%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        clear_logs();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp += 2;
        if (ev_in_ready !== 1'b0 || ev_load_busy !== 1'b0 || ev_word_count !== '0) begin
            n_fail++; $display("FAIL abort_idle got ready=%b busy=%b count=%0d want 0/0/0", ev_in_ready, ev_load_busy, ev_word_count);
        end
        if (obs_q.size() !== 1) begin n_fail++; $display("FAIL abort_nwr got %0d want 1", obs_q.size()); end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_q.size() !== 1) begin n_fail++; $display("FAIL abort_lo_nwr got %0d want 1", obs_q.size()); end
        clear_logs();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL refill_nwr got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                n_cmp++;
                if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                    n_fail++; $display("FAIL refill_wr%0d got a=%0d d=%h want a=%0d d=%h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        clear_logs();
        step(1'b1, 32'h1234, 1'b1, 1'b1);
        step(1'b1, 32'h5678, 1'b0, 1'b0);
        n_cmp++;
        if (ev_in_ready !== 1'b0 || ev_load_busy !== 1'b0 || obs_q.size() !== 0) begin
            n_fail++; $display("FAIL simul got ready=%b busy=%b nwr=%0d want 0/0/0", ev_in_ready, ev_load_busy, obs_q.size());
        end
    endtask

    task automatic test_async_reset();
        clear_logs();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (EVrandombit_wea !== 8'h00 || EVrandombit_addra !== '0 || EVrandombit_dina !== 64'h0) begin
            n_fail++; $display("FAIL arst_port got wea=%h a=%0d d=%h want 00/0/0", EVrandombit_wea, EVrandombit_addra, EVrandombit_dina);
        end
        if (ev_in_ready !== 1'b0 || ev_load_busy !== 1'b0 || ev_word_count !== '0 || EVrandombit_full !== 1'b0) begin
            n_fail++; $display("FAIL arst_ctl got ready=%b busy=%b count=%0d full=%b want 0/0/0/0", ev_in_ready, ev_load_busy, ev_word_count, EVrandombit_full);
        end
        m_active = 0; m_full = 0; m_nw = 0; m_count = 0; m_ck = '0;
        ev_in_valid = 1'b0; start_ev_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_checksum();
`ifdef EV_LOADER_CHECKSUM_EN
        logic [31:0] words [4];
        words[0] = 32'hA5A5A5A5; words[1] = 32'h0F0F0F0F; words[2] = 32'hFFFFFFFF; words[3] = 32'h00000000;
        clear_logs();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        foreach (words[i]) step(1'b1, words[i], 1'b0, 1'b0);
        n_cmp++;
        if (ev_checksum !== 32'h55555555) begin n_fail++; $display("FAIL cks_vec got %h want 55555555", ev_checksum); end
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0);
        n_cmp++;
        if (ev_checksum !== m_ck) begin n_fail++; $display("FAIL cks_full got %h want %h", ev_checksum, m_ck); end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_cmp++;
        if (ev_checksum !== 32'h0) begin n_fail++; $display("FAIL cks_clr got %h want 0", ev_checksum); end
`endif
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 4; r++) begin
            clear_logs();
            for (int c = 0; c < 120; c++) begin
                step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) == 0));
                n_cmp++;
                if (ev_in_ready !== 1'(m_active) || ev_load_busy !== 1'(m_active) ||
                    EVrandombit_full !== 1'(m_full) || ev_word_count !== 3'(m_count)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_c%0d got ready=%b busy=%b full=%b count=%0d want %b/%b/%b/%0d", r, c, ev_in_ready,
                             ev_load_busy, EVrandombit_full, ev_word_count, m_active, m_active, m_full, m_count);
                end
`ifdef EV_LOADER_CHECKSUM_EN
                n_cmp++;
                if (ev_checksum !== m_ck) begin n_fail++; $display("FAIL rnd%0d_cks%0d got %h want %h", r, c, ev_checksum, m_ck); end
`endif
            end
            step(1'b0, 32'h0, 1'b0, 1'b0);
            n_cmp++;
            if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_nwr got %0d want %0d", r, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) begin
                if (i < obs_q.size()) begin
                    n_cmp++;
                    if (obs_q[i].wea !== 8'hFF || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                        n_fail++; $display("FAIL rnd%0d_wr%0d got a=%0d d=%h want a=%0d d=%h", r, i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic_fill();
        test_backpressure();
        test_abort();
        test_simultaneous();
        test_async_reset();
        test_checksum();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
